// File: rtl/operand_vector_loader.sv
// operand_vector_loader: serial-to-parallel operand distributor.
// Collects NUM_OUTPUTS signed words, one per in_valid/in_ready beat, into a
// fill buffer and presents each complete vector on a registered, held-stable
// valid/ready output. The buffering is double: the next vector fills while the
// current one waits at the output. A vector whose last word arrives while the
// output is free (or being taken) goes straight to out_vec with no bubble.
module operand_vector_loader #(
   parameter  int NUM_OUTPUTS = 36,
   parameter  int DATA_WIDTH  = 32,
   localparam int CW          = $clog2(NUM_OUTPUTS + 1)
) (
   input  logic                         clk,
   input  logic                         arst_in,
   input  logic                         clear_in,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic signed [DATA_WIDTH-1:0] out_vec [0:NUM_OUTPUTS-1],
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CW-1:0]                fill_count
);

   // FILL: fill buffer has room. FULL: fill buffer complete, waiting for the output.
   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t                       state;
   state_t                       next_state;
   logic [CW-1:0]                fill_cnt;
   logic [CW-1:0]                fill_nxt;
   logic                         valid_nxt;
   logic signed [DATA_WIDTH-1:0] fill_buf [0:NUM_OUTPUTS-1];

   logic in_fire;
   logic out_fire;
   logic last_word;
   logic out_free;
   logic store;        // write in_data into fill_buf[fill_cnt]
   logic xfer_direct;  // out_vec <= fill_buf with last lane taken from in_data
   logic xfer_buf;     // out_vec <= complete fill_buf

   assign in_ready   = (state == FILL) && !clear_in;
   assign in_fire    = in_valid && in_ready;
   assign out_fire   = out_valid && out_ready;
   assign last_word  = (fill_cnt == CW'(NUM_OUTPUTS - 1));
   assign out_free   = !out_valid || out_ready;
   assign fill_count = fill_cnt;

   // Next-state and datapath control; clear_in overrides every other event.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      next_state  = state;
      fill_nxt    = fill_cnt;
      valid_nxt   = out_valid;
      store       = 1'b0;
      xfer_direct = 1'b0;
      xfer_buf    = 1'b0;
      if (clear_in) begin
         next_state = FILL;
         fill_nxt   = '0;
         valid_nxt  = 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (in_fire && !last_word) begin
                  store    = 1'b1;
                  fill_nxt = fill_cnt + 1'b1;
               end else if (in_fire && out_free) begin
                  // Last word with the output free or leaving: transfer wins.
                  xfer_direct = 1'b1;
                  valid_nxt   = 1'b1;
                  fill_nxt    = '0;
               end else if (in_fire) begin
                  // Last word while the output is stalled: park the vector.
                  store      = 1'b1;
                  fill_nxt   = CW'(NUM_OUTPUTS);
                  next_state = FULL;
               end
               if (out_fire && !xfer_direct) begin
                  valid_nxt = 1'b0;
               end
            end
            FULL: begin
               if (out_fire) begin
                  xfer_buf   = 1'b1;
                  valid_nxt  = 1'b1;
                  fill_nxt   = '0;
                  next_state = FILL;
               end
            end
            default: begin
               next_state = FILL;
               fill_nxt   = '0;
               valid_nxt  = 1'b0;
            end
         endcase
      end
   end

   // Control state register: FSM state, fill counter and output valid.
   always_ff @(posedge clk or posedge arst_in) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (arst_in) begin
         state     <= FILL;
         fill_cnt  <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= next_state;
         fill_cnt  <= fill_nxt;
         out_valid <= valid_nxt;
      end
   end

   // Operand storage: lane writes into the fill buffer and vector transfers to out_vec.
   always_ff @(posedge clk or posedge arst_in) begin
      // NOTE: the buffers are reset so the output vector reads all-zero after
      // reset; this costs a reset net on every storage bit, which is intended.
      if (arst_in) begin
         for (int i = 0; i < NUM_OUTPUTS; i++) begin
            fill_buf[i] <= '0;
            out_vec[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (store && (fill_cnt == CW'(i))) begin
               fill_buf[i] <= in_data;
            end
         end
         if (xfer_direct) begin
            for (int i = 0; i < NUM_OUTPUTS - 1; i++) begin
               out_vec[i] <= fill_buf[i];
            end
            out_vec[NUM_OUTPUTS-1] <= in_data;
         end else if (xfer_buf) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
               out_vec[i] <= fill_buf[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_operand_vector_loader.sv
// Testbench for operand_vector_loader (NUM_OUTPUTS=4, DATA_WIDTH=8).
// The driver applies stimulus and records accepted words into a reference
// model: a queue of words for the partial vector and a queue of complete
// vectors awaiting the consumer. The monitor compares DUT outputs with the
// model every cycle and retires a vector whenever the consumer takes one.
module tb_operand_vector_loader;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int CW = $clog2(N + 1);

   logic                clk;
   logic                arst_in;
   logic                clear_in;
   logic signed [W-1:0] in_data;
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] out_vec [0:N-1];
   logic                out_valid;
   logic                out_ready;
   logic [CW-1:0]       fill_count;

   operand_vector_loader #(
      .NUM_OUTPUTS (N),
      .DATA_WIDTH  (W)
   ) dut (
      .clk        (clk),
      .arst_in    (arst_in),
      .clear_in   (clear_in),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_vec    (out_vec),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fill_count (fill_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: words of the vector being filled, and finished vectors
   // (lane 0 in the low byte) not yet taken by the consumer.
   logic [W-1:0]   part_q [$];
   logic [N*W-1:0] exp_q  [$];

   int n_checks = 0;
   int n_pass   = 0;
   int n_vec    = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
   endtask

   function automatic logic [63:0] pack_out();
      logic [63:0] p = '0;
      for (int i = 0; i < N; i++) p[i*W +: W] = out_vec[i];
      return p;
   endfunction

   function automatic logic [63:0] vec4(input int a, input int b, input int c, input int d);
      logic [7:0] la = a[7:0];
      logic [7:0] lb = b[7:0];
      logic [7:0] lc = c[7:0];
      logic [7:0] ld = d[7:0];
      return {32'h0, ld, lc, lb, la};
   endfunction

   // Monitor: compare against the model at every falling edge, retire taken vectors.
   always @(negedge clk) begin
      if (!arst_in) begin
         check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
         check("fill_count", 64'(fill_count), (exp_q.size() == 2) ? 64'(N) : 64'(part_q.size()));
         check("in_ready", 64'(in_ready), 64'(!clear_in && (exp_q.size() != 2)));
         if (out_valid && exp_q.size() > 0) check("out_vec", pack_out(), 64'(exp_q[0]));
         if (out_valid && out_ready && !clear_in && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            n_vec++;
         end
      end
   end

   // One clock of stimulus; updates the model with what the DUT accepted.
   task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy,
                        input logic clr, output logic acc);
      logic [N*W-1:0] vec;
      @(posedge clk);
      #2;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      clear_in  = clr;
      @(negedge clk);
      #1;
      acc = in_valid && in_ready;
      if (clr) begin
         part_q.delete();
         exp_q.delete();
      end else if (acc) begin
         part_q.push_back(d);
         if (part_q.size() == N) begin
            for (int i = 0; i < N; i++) vec[i*W +: W] = part_q[i];
            exp_q.push_back(vec);
            part_q.delete();
         end
      end
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      drive(1'b0, '0, ordy, 1'b0, acc);
   endtask

   // Offer one word until accepted, within a bounded number of cycles.
   task automatic send(input int d, input logic ordy);
      logic acc = 1'b0;
      logic [31:0] dv = d;
      for (int t = 0; t < 50 && !acc; t++) drive(1'b1, dv[W-1:0], ordy, 1'b0, acc);
      check("send_accepted", 64'(acc), 64'(1));
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset();
      @(posedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      clear_in  = 1'b0;
      #3;
      arst_in = 1'b1;
      part_q.delete();
      exp_q.delete();
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_fill_count", 64'(fill_count), 64'(0));
      #3;
      arst_in = 1'b0;
   endtask

   initial begin
      logic acc;
      int   start_vec;
      int   cyc;

      arst_in   = 1'b1;
      clear_in  = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #1;
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_fill_count", 64'(fill_count), 64'(0));
      check("reset_out_vec", pack_out(), 64'(0));
      check("reset_in_ready", 64'(in_ready), 64'(1));
      #11;
      arst_in = 1'b0;

      // 1: single vector with a negative last word, consumer always ready.
      send(1, 1'b1); send(2, 1'b1); send(3, 1'b1); send(-4, 1'b1);
      idle(1'b1);
      check("t1_out_valid", 64'(out_valid), 64'(1));
      check("t1_out_vec", pack_out(), vec4(1, 2, 3, -4));
      idle(1'b1);
      check("t1_valid_drop", 64'(out_valid), 64'(0));
      check("t1_fill_count", 64'(fill_count), 64'(0));

      // 2: two back-to-back vectors, no stall on the input side.
      for (int k = 10; k < 18; k++) begin
         logic [31:0] kv = k;
         drive(1'b1, kv[W-1:0], 1'b1, 1'b0, acc);
         check("t2_in_accept", 64'(acc), 64'(1));
      end
      idle(1'b1);
      idle(1'b1);

      // 3: consumer stalled while two vectors arrive.
      for (int k = 1; k <= 8; k++) send(k, 1'b0);
      idle(1'b0);
      check("t3_fill_count", 64'(fill_count), 64'(N));
      check("t3_in_ready", 64'(in_ready), 64'(0));
      check("t3_held_vec", pack_out(), vec4(1, 2, 3, 4));
      idle(1'b1);
      idle(1'b0);
      check("t3_second_vec", pack_out(), vec4(5, 6, 7, 8));
      check("t3_second_valid", 64'(out_valid), 64'(1));
      check("t3_in_ready_back", 64'(in_ready), 64'(1));
      idle(1'b1);
      idle(1'b1);

      // 4: clear drops a partial fill, then clear drops a held vector.
      send(30, 1'b1); send(31, 1'b1);
      drive(1'b1, 8'd99, 1'b1, 1'b1, acc);
      check("t4_clear_in_ready", 64'(in_ready), 64'(0));
      send(20, 1'b1); send(21, 1'b1); send(22, 1'b1); send(23, 1'b1);
      idle(1'b0);
      check("t4_vec_after_clear", pack_out(), vec4(20, 21, 22, 23));
      drive(1'b0, '0, 1'b0, 1'b1, acc);
      idle(1'b0);
      check("t4_clear_drops_valid", 64'(out_valid), 64'(0));

      // 5: asynchronous reset mid-fill and while a vector is held.
      send(40, 1'b1); send(41, 1'b1); send(42, 1'b1);
      idle(1'b1);
      check("t5_fill3", 64'(fill_count), 64'(3));
      pulse_reset();
      send(50, 1'b1); send(51, 1'b1); send(52, 1'b1); send(53, 1'b1);
      idle(1'b0);
      check("t5_fresh_vec", pack_out(), vec4(50, 51, 52, 53));
      pulse_reset();
      send(60, 1'b1); send(61, 1'b1); send(62, 1'b1); send(63, 1'b1);
      idle(1'b0);
      check("t5_fresh_vec2", pack_out(), vec4(60, 61, 62, 63));
      idle(1'b1);

      // 6: random traffic until 1000 vectors have been taken by the consumer.
      start_vec = n_vec;
      cyc = 0;
      while ((n_vec - start_vec) < 1000 && cyc < 40000) begin
         drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 63) == 0), acc);
         cyc++;
      end
      check("t6_vectors_done", 64'((n_vec - start_vec) >= 1000), 64'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
